// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: read-domain consumer of an async FIFO. It pops words into a
// 2-entry registered buffer and presents them as a valid/ready stream.
// Optional delivered-word counter: define FIFO_RD_WORD_COUNT_EN to add M_count.
module fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  R_CLK,
    input  logic                  R_rst_n,
    input  logic                  R_empty,
    input  logic [DATA_WIDTH-1:0] R_data,
    output logic                  R_inc,
    input  logic                  R_flush,
    output logic                  M_valid,
    input  logic                  M_ready,
`ifdef FIFO_RD_WORD_COUNT_EN
    output logic [CNT_WIDTH-1:0]  M_count,
`endif
    output logic [DATA_WIDTH-1:0] M_data
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;
    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic                  acc;
    assign M_valid = state_q != EMPTY;
    assign M_data  = e0_q;
    assign R_inc   = ~R_empty & (state_q != TWO) & ~R_flush;
    assign acc     = M_valid & M_ready;
    // Occupancy transitions; R_inc is the pop, so words are captured on the pointer-advance edge.
    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (R_flush)
            state_d = EMPTY;
        else
            case (state_q)
                EMPTY: if (R_inc) begin
                    e0_d    = R_data;
                    state_d = ONE;
                end
                ONE: if (R_inc && acc)
                    e0_d = R_data;
                else if (R_inc) begin
                    e1_d    = R_data;
                    state_d = TWO;
                end else if (acc)
                    state_d = EMPTY;
                TWO: if (acc) begin
                    e0_d    = e1_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
    end
    // Buffer registers with asynchronous clear.
    always_ff @(posedge R_CLK or negedge R_rst_n) begin
        if (!R_rst_n) begin
            state_q <= EMPTY;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end
`ifdef FIFO_RD_WORD_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    assign cnt_d   = (acc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    assign M_count = cnt_q;
    // Saturating count of accepted words; flush does not clear it.
    always_ff @(posedge R_CLK or negedge R_rst_n) begin
        if (!R_rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`endif
endmodule

// File: doc/fifo_rd_stream_if.md
Name: fifo_rd_stream_if

Overview:
Read-domain consumer end of the async FIFO. It drives R_inc against R_empty and the FIFO memory read data, and presents the words as a valid/ready stream on a 2-entry registered output buffer. Full throughput is one word per R_CLK. R_inc has no combinational path from the downstream M_ready.

Parameters:
DATA_WIDTH, 8, width of FIFO words and M_data
CNT_WIDTH, 16, width of delivered-word counter (optional feature only)

Ports:
R_CLK  in  1  read-domain clock
R_rst_n  in  1  reset; asynchronous, active-low
R_empty  in  1  registered empty flag from read-pointer block
R_data  in  DATA_WIDTH  FIFO memory word at the current read address, valid whenever R_empty=0
R_inc  out  1  pop request to read-pointer block
R_flush  in  1  synchronous flush; discards buffered words
M_valid  out  1  output word valid
M_ready  in  1  downstream accept
M_data  out  DATA_WIDTH  output word (head of buffer)
M_count  out  CNT_WIDTH  delivered-word count (present only with the optional feature)

Behaviour:
- Reset (R_rst_n=0, async): state EMPTY, both entries 0, M_valid=0, M_data=0, M_count=0. R_inc=0, because it is gated by the reset-forced R_empty=1.
- Internal buffer: entry0 is the head and drives M_data; entry1 is the skid entry. Occupancy state is EMPTY(0), ONE(1) or TWO(2), held in registers.
- M_valid = (state != EMPTY), decoded from registers only.
- Combinational pop: R_inc = ~R_empty & (state != TWO) & ~R_flush. It depends only on R_empty, the state register and R_flush.
- pop = R_inc. Words are captured from R_data on the same R_CLK edge at which the pointer advances.
- acc = M_valid & M_ready.
- Transitions, evaluated at each R_CLK edge with R_flush=0:
  - EMPTY: pop -> entry0 <= R_data, go to ONE; else stay.
  - ONE, pop & acc -> entry0 <= R_data, stay ONE.
  - ONE, pop & ~acc -> entry1 <= R_data, go to TWO.
  - ONE, ~pop & acc -> go to EMPTY.
  - ONE, neither -> hold.
  - TWO (pop impossible): acc -> entry0 <= entry1, go to ONE; else hold.
- R_flush=1: next state EMPTY regardless of acc. R_inc forced 0, so no FIFO word is consumed or lost. An acc in the flush cycle still counts as a delivered word.
- Latency: a word at the FIFO head while state=EMPTY appears on M_valid exactly 1 cycle after the pop edge.
- Ordering is strictly FIFO, with no duplication or drop except by flush.
- M_data is stable while M_valid=1 and M_ready=0.
- Entry contents beyond the occupancy are don't-care but must not change M_data while valid.
- Reset asserted mid-stream: buffered words are discarded; outputs return to reset values immediately (async).

Optional Feature:
Macro: FIFO_RD_WORD_COUNT_EN
- Defined: M_count port exists. It increments by 1 on every acc, saturates at 2^CNT_WIDTH-1, is cleared only by reset, and is unaffected by R_flush.
- Not defined: no M_count port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset, R_empty=1, M_ready=1 -> R_inc=0, M_valid=0, M_data=0, state EMPTY for 10 cycles.
- FIFO holds 0x11,0x22,0x33 (R_empty=0 until popped out), M_ready=1 constantly -> R_inc high 3 consecutive cycles; M_valid high 3 consecutive cycles starting 1 cycle after first pop; M_data 0x11,0x22,0x33 in order.
- Same 3 words, M_ready=0 -> exactly 2 pops (state TWO), R_inc=0 thereafter, M_data=0x11 held. Then M_ready=1 -> 0x11,0x22,0x33 delivered with no gap after the third pop.
- State TWO holding 0xA0,0xA1, FIFO head 0xA2, R_flush pulsed 1 cycle with M_ready=0 -> M_valid=0 next cycle, R_inc=0 during flush. Next stream word is 0xA2; 0xA0/0xA1 are never re-delivered.
- R_rst_n asserted while state TWO -> M_valid drops to 0 asynchronously before the next edge. After release with R_empty=1, no output.
- With FIFO_RD_WORD_COUNT_EN, CNT_WIDTH=4, deliver 20 words with random M_ready -> M_count=15 after the 15th accept and stays 15; a flush does not clear it.
